// File: rtl/snow_anim_sched.sv
// Snow animation scheduler: divides clk into animation ticks, groups ticks into
// sequence steps and applies each step's frame change only on a vsync boundary.
module snow_anim_sched #(
    parameter int          TICK_DIV = 6000000,
    parameter int          HOLD     = 4,
    parameter int          SEQ_LEN  = 4,
    parameter logic [23:0] SEQ      = 24'h000088
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       pause,
    input  logic       restart,
    input  logic       vsync,
    output logic [2:0] frame_sel,
    output logic [2:0] step_idx,
    output logic       frame_upd,
    output logic       running,
    output logic       overrun,
    output logic [1:0] state_dbg
);

    localparam int          TW        = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [3:0]  HOLD_LAST = 4'(HOLD - 1);
    localparam logic [2:0]  STEP_LAST = 3'(SEQ_LEN - 1);
    localparam logic [23:0] SEQ_V     = SEQ;
    localparam logic [2:0]  FRAME0    = SEQ_V[2:0];

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    state_t          state;
    logic [TW-1:0]   tick_cnt;
    logic [3:0]      hold_cnt;
    logic            pending;

    logic            tick;
    logic            step_req;
    logic [2:0]      step_nxt;
    logic [2:0]      frame_nxt;

    function automatic logic [2:0] seq_frame(input logic [2:0] s);
        logic [23:0] sh;
        sh = SEQ_V >> ({2'b00, s} * 5'd3);
        return sh[2:0];
    endfunction

    assign state_dbg = state;

    always_comb begin
        tick      = (tick_cnt == TICK_LAST);
        step_req  = tick && (hold_cnt == HOLD_LAST);
        step_nxt  = (step_idx == STEP_LAST) ? 3'd0 : step_idx + 3'd1;
        frame_nxt = seq_frame(step_nxt);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            tick_cnt  <= '0;
            hold_cnt  <= '0;
            pending   <= 1'b0;
            step_idx  <= 3'd0;
            frame_sel <= FRAME0;
            frame_upd <= 1'b0;
            running   <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_upd <= 1'b0;
            if (!en) begin
                // Disable keeps the displayed frame so the snow does not jump.
                state    <= ST_IDLE;
                running  <= 1'b0;
                tick_cnt <= '0;
                hold_cnt <= '0;
                pending  <= 1'b0;
            end else if (restart && state != ST_IDLE) begin
                tick_cnt  <= '0;
                hold_cnt  <= '0;
                pending   <= 1'b0;
                step_idx  <= 3'd0;
                frame_sel <= FRAME0;
                frame_upd <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state   <= ST_RUN;
                        running <= 1'b1;
                    end
                    ST_RUN: begin
                        if (pause) begin
                            state   <= ST_PAUSE;
                            running <= 1'b0;
                        end else begin
                            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
                            if (tick)
                                hold_cnt <= (hold_cnt == HOLD_LAST) ? 4'd0 : hold_cnt + 4'd1;
                            // Frame changes only land on a vsync so a frame is never torn.
                            if (vsync && (pending || step_req)) begin
                                step_idx  <= step_nxt;
                                frame_sel <= frame_nxt;
                                pending   <= 1'b0;
                                frame_upd <= 1'b1;
                            end else if (step_req) begin
                                if (pending)
                                    overrun <= 1'b1;
                                pending <= 1'b1;
                            end
                        end
                    end
                    ST_PAUSE: begin
                        if (!pause) begin
                            state   <= ST_RUN;
                            running <= 1'b1;
                        end
                    end
                    default: begin
                        state   <= ST_IDLE;
                        running <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_snow_anim_sched.sv
// Directed bench for snow_anim_sched with TICK_DIV=3, HOLD=2, SEQ_LEN=4 and the
// default frame sequence 0,1,2,0; one step request every 6 RUN cycles.
module tb_snow_anim_sched;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       pause;
    logic       restart;
    logic       vsync;
    logic [2:0] frame_sel;
    logic [2:0] step_idx;
    logic       frame_upd;
    logic       running;
    logic       overrun;
    logic [1:0] state_dbg;

    int checks = 0;
    int errors = 0;

    logic [2:0] exp_q[$];

    snow_anim_sched #(
        .TICK_DIV (3),
        .HOLD     (2),
        .SEQ_LEN  (4),
        .SEQ      (24'h000088)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .pause     (pause),
        .restart   (restart),
        .vsync     (vsync),
        .frame_sel (frame_sel),
        .step_idx  (step_idx),
        .frame_upd (frame_upd),
        .running   (running),
        .overrun   (overrun),
        .state_dbg (state_dbg)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        en      = 1'b0;
        pause   = 1'b0;
        restart = 1'b0;
        vsync   = 1'b0;
        cyc(2);
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        int upd_cnt;
        logic [2:0] e;

        // Reset state
        do_reset();
        chk("rst_step", 32'(step_idx), 0);
        chk("rst_frame", 32'(frame_sel), 0);
        chk("rst_upd", 32'(frame_upd), 0);
        chk("rst_running", 32'(running), 0);
        chk("rst_overrun", 32'(overrun), 0);
        chk("rst_state", 32'(state_dbg), 0);

        // Basic sequencing with vsync held high
        en = 1'b1; vsync = 1'b1;
        cyc(1);
        chk("t1_running", 32'(running), 1);
        chk("t1_state", 32'(state_dbg), 1);
        exp_q.push_back(3'd1);
        exp_q.push_back(3'd2);
        exp_q.push_back(3'd0);
        exp_q.push_back(3'd0);
        for (int k = 0; k < 4; k++) begin
            n = 0;
            do begin
                cyc(1);
                n++;
            end while (!frame_upd && n < 20);
            chk("t1_latency", 32'(n), 6);
            chk("t1_step", 32'(step_idx), 32'((k + 1) % 4));
            e = exp_q.pop_front();
            chk("t1_frame", 32'(frame_sel), 32'(e));
        end

        // Vsync gating: request waits for vsync
        do_reset();
        en = 1'b1;
        cyc(1);
        cyc(6);
        chk("t2_frame_wait", 32'(frame_sel), 0);
        chk("t2_step_wait", 32'(step_idx), 0);
        chk("t2_upd_wait", 32'(frame_upd), 0);
        cyc(3);
        chk("t2_frame_pre", 32'(frame_sel), 0);
        vsync = 1'b1;
        cyc(1);
        chk("t2_frame_adv", 32'(frame_sel), 1);
        chk("t2_step_adv", 32'(step_idx), 1);
        chk("t2_upd_adv", 32'(frame_upd), 1);
        vsync = 1'b0;
        cyc(2);
        chk("t2_overrun", 32'(overrun), 0);
        chk("t2_frame_hold", 32'(frame_sel), 1);

        // Overrun: two requests without vsync
        do_reset();
        en = 1'b1;
        cyc(1);
        cyc(11);
        chk("t3_overrun_pre", 32'(overrun), 0);
        cyc(1);
        chk("t3_overrun_set", 32'(overrun), 1);
        chk("t3_step_pre", 32'(step_idx), 0);
        cyc(1);
        vsync = 1'b1;
        cyc(1);
        chk("t3_step_adv", 32'(step_idx), 1);
        chk("t3_frame_adv", 32'(frame_sel), 1);
        chk("t3_upd_adv", 32'(frame_upd), 1);
        vsync = 1'b0;
        cyc(1);
        chk("t3_upd_clear", 32'(frame_upd), 0);
        chk("t3_step_once", 32'(step_idx), 1);
        chk("t3_overrun_sticky", 32'(overrun), 1);

        // Pause with a pending request, vsync pulses ignored
        do_reset();
        en = 1'b1;
        cyc(1);
        cyc(8);
        pause = 1'b1;
        cyc(1);
        chk("t4_running", 32'(running), 0);
        chk("t4_state", 32'(state_dbg), 2);
        upd_cnt = 0;
        for (int i = 10; i <= 27; i++) begin
            cyc(1);
            if (frame_upd) upd_cnt++;
            vsync = (i == 12 || i == 20);
        end
        chk("t4_upd_in_pause", 32'(upd_cnt), 0);
        chk("t4_step_frozen", 32'(step_idx), 0);
        chk("t4_overrun_frozen", 32'(overrun), 0);
        cyc(1);
        pause = 1'b0;
        cyc(1);
        chk("t4_resume_running", 32'(running), 1);
        cyc(3);
        chk("t4_overrun_before", 32'(overrun), 0);
        cyc(1);
        chk("t4_overrun_resume", 32'(overrun), 1);
        vsync = 1'b1;
        cyc(1);
        chk("t4_step_adv", 32'(step_idx), 1);
        chk("t4_frame_adv", 32'(frame_sel), 1);
        chk("t4_upd_adv", 32'(frame_upd), 1);
        vsync = 1'b0;

        // Restart and vsync together at step 2 with pending set
        do_reset();
        en = 1'b1; vsync = 1'b1;
        cyc(1);
        cyc(12);
        chk("t5_step2", 32'(step_idx), 2);
        chk("t5_frame2", 32'(frame_sel), 2);
        vsync = 1'b0;
        cyc(6);
        chk("t5_step_pend", 32'(step_idx), 2);
        restart = 1'b1; vsync = 1'b1;
        cyc(1);
        chk("t5_step_rst", 32'(step_idx), 0);
        chk("t5_frame_rst", 32'(frame_sel), 0);
        chk("t5_upd_rst", 32'(frame_upd), 1);
        chk("t5_running", 32'(running), 1);
        restart = 1'b0; vsync = 1'b0;
        cyc(1);
        chk("t5_upd_clear", 32'(frame_upd), 0);
        cyc(5);
        chk("t5_overrun", 32'(overrun), 0);
        vsync = 1'b1;
        cyc(1);
        chk("t5_step_after", 32'(step_idx), 1);
        chk("t5_frame_after", 32'(frame_sel), 1);
        vsync = 1'b0;

        // Disable at step 2, restart ignored in IDLE, then reset
        do_reset();
        en = 1'b1; vsync = 1'b1;
        cyc(1);
        cyc(12);
        vsync = 1'b0;
        cyc(12);
        chk("t6_overrun", 32'(overrun), 1);
        chk("t6_step2", 32'(step_idx), 2);
        en = 1'b0;
        cyc(1);
        chk("t6_idle_running", 32'(running), 0);
        chk("t6_idle_state", 32'(state_dbg), 0);
        chk("t6_idle_frame", 32'(frame_sel), 2);
        chk("t6_idle_step", 32'(step_idx), 2);
        chk("t6_idle_overrun", 32'(overrun), 1);
        en = 1'b1; vsync = 1'b1; restart = 1'b1;
        cyc(1);
        chk("t6_norestart_step", 32'(step_idx), 2);
        chk("t6_norestart_frame", 32'(frame_sel), 2);
        chk("t6_rerun", 32'(running), 1);
        chk("t6_norestart_upd", 32'(frame_upd), 0);
        restart = 1'b0;
        cyc(1);
        chk("t6_nopend_step", 32'(step_idx), 2);
        chk("t6_nopend_upd", 32'(frame_upd), 0);
        rst_n = 1'b0;
        cyc(1);
        chk("t6_rst_step", 32'(step_idx), 0);
        chk("t6_rst_frame", 32'(frame_sel), 0);
        chk("t6_rst_overrun", 32'(overrun), 0);
        chk("t6_rst_running", 32'(running), 0);
        chk("t6_rst_state", 32'(state_dbg), 0);
        rst_n = 1'b1;
        vsync = 1'b0;
        cyc(2);

        // Final report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/snow_anim_sched.md
SNOW_ANIM_SCHED -- requirements
Module: snow_anim_sched

Interface
REQ-001 SHALL have parameter TICK_DIV, default 6000000, giving clk cycles per animation tick (>=2).
REQ-002 SHALL have parameter HOLD, default 4, giving ticks per sequence step (1..15).
REQ-003 SHALL have parameter SEQ_LEN, default 4, giving the number of sequence steps (1..8).
REQ-004 SHALL have parameter SEQ, 24 bits, default 24'h000088, holding packed 3-bit frame ids per step, step 0 in bits [2:0]; the default sequence is frames 0,1,2,0.
REQ-005 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-007 SHALL have port en, input, 1 bit: animation enable, level.
REQ-008 SHALL have port pause, input, 1 bit: freeze the animation, level.
REQ-009 SHALL have port restart, input, 1 bit: single-cycle strobe that rewinds to step 0.
REQ-010 SHALL have port vsync, input, 1 bit: single-cycle frame-boundary strobe from the VGA timing.
REQ-011 SHALL have port frame_sel, output, 3 bits: selects which frame ROM drives the snow pixel mux.
REQ-012 SHALL have port step_idx, output, 3 bits: current sequence step.
REQ-013 SHALL have port frame_upd, output, 1 bit: pulse marking a frame_sel change.
REQ-014 SHALL have port running, output, 1 bit: high in the RUN state.
REQ-015 SHALL have port overrun, output, 1 bit: sticky flag for a dropped step request.

Function
REQ-016 SHALL implement the states IDLE, RUN and PAUSE; all outputs SHALL be registered.
REQ-017 SHALL apply this priority each cycle: rst_n low > en low > restart > pause > normal operation.
REQ-018 SHALL, in IDLE, hold tick_cnt, hold_cnt and pending at 0 and go to RUN on the next edge when en=1.
REQ-019 SHALL, in RUN, count tick_cnt 0..TICK_DIV-1, wrapping to 0 and raising an internal tick on the wrap cycle.
REQ-020 SHALL, on each tick, increment hold_cnt; when hold_cnt=HOLD-1 it SHALL clear hold_cnt and raise a step request.
REQ-021 SHALL, on a step request, set pending; if pending is already set and no vsync occurs in that cycle, it SHALL drop the request and set overrun (sticky until reset).
REQ-022 SHALL, when vsync=1 and (pending=1 or a step request occurs in the same cycle), at that edge:
- advance step_idx, wrapping from SEQ_LEN-1 to 0;
- load frame_sel with SEQ[3*new_step +: 3];
- clear pending;
- assert frame_upd for exactly the next cycle.
REQ-023 SHALL, when vsync=1 with no pending request, change nothing.
REQ-024 SHALL go from RUN to PAUSE when pause=1, and from PAUSE back to RUN when pause=0.
REQ-025 SHALL, in PAUSE, freeze tick_cnt and hold_cnt, retain pending, and ignore vsync (no step advance).
REQ-026 SHALL, on restart=1 in RUN or PAUSE:
- clear tick_cnt, hold_cnt and pending;
- set step_idx=0 and frame_sel=SEQ[2:0];
- pulse frame_upd for the next cycle;
- keep the current state.
REQ-027 SHALL ignore restart in IDLE.
REQ-028 SHALL, on en=0 in any state, go to IDLE and clear the counters and pending; step_idx and frame_sel SHALL retain their values.
REQ-029 SHALL drive running=1 exactly while the state is RUN.
REQ-030 SHALL raise frame_upd only on a step advance or a restart, never on other cycles.

Reset
REQ-031 SHALL, while rst_n=0 at a clock edge, set:
- state=IDLE;
- tick_cnt=0, hold_cnt=0, pending=0;
- step_idx=0, frame_sel=SEQ[2:0] (0 by default);
- frame_upd=0, running=0, overrun=0.
REQ-032 SHALL apply reset mid-operation in the same way, with no partial step advance.

Verification (TICK_DIV=3, HOLD=2, SEQ_LEN=4, default SEQ)
REQ-033 Basic sequencing: en=1 with vsync held high -> step_idx 1,2,3,0 and frame_sel 1,2,0,0, advancing every 6 RUN cycles, with a one-cycle frame_upd pulse each time.
REQ-034 Vsync gating: vsync low when the request is raised, then high 10 cycles later -> frame_sel stays 0 until the cycle after vsync, then becomes 1; overrun stays 0.
REQ-035 Overrun: vsync held low for 14 RUN cycles -> one step stays pending, the second request sets overrun=1, and the next vsync advances exactly one step.
REQ-036 Pause: pause held for 20 cycles mid-count -> tick_cnt and hold_cnt are frozen, vsync pulses cause no advance, and counting resumes from the frozen values.
REQ-037 Restart with vsync: restart and vsync in the same cycle while pending is set at step 2 -> step_idx=0, frame_sel=0, pending cleared, one frame_upd pulse.
REQ-038 Disable and reset: en dropped at step 2 -> IDLE, running=0, frame_sel still 2; then rst_n=0 for 1 cycle -> step_idx=0, frame_sel=0, overrun=0.
